// File: rtl/intlv_bank_scheduler.sv
// ---------------------------------------------------------------------------
// intlv_bank_scheduler
// Ping-pong scheduler for the interleaver's two block RAM banks.
// The writer claims a free bank for each incoming CRC block and produces
// linear write addresses. The reader drains full banks in arrival order and
// produces a linear read index for the QPP address generator. Both sides run
// at the same time on opposite banks.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   blk_start  request to start a new block (1-cycle pulse)
//   blk_size   sampled with blk_start: 0=K_SMALL, 1=K_LARGE
//   in_valid   input sample present
//   in_end     with in_valid: this sample ends the block early
//   in_ready   writer owns a bank; samples accepted only when high
//   wr_en      RAM write strobe (in_valid & in_ready)
//   wr_bank    bank being written
//   wr_addr    linear write address within wr_bank
//   rd_valid   read index valid
//   rd_ready   downstream accepts the current index
//   rd_bank    bank being drained
//   rd_idx     linear read index 0..rd_k-1
//   rd_k       recorded length of the bank being drained
//   rd_last    final index of the bank
//   blk_done   pulse the cycle after a bank's final read transfer
//   drop       pulse the cycle after a rejected blk_start
//   drop_cnt   saturating rejected-start counter
//
// Build option: define INTLV_SCHED_ERRCNT_EN to implement drop_cnt;
// otherwise drop_cnt is constant zero.
// ---------------------------------------------------------------------------
module intlv_bank_scheduler #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_start,
  input  logic             blk_size,
  input  logic             in_valid,
  input  logic             in_end,
  output logic             in_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [CNT_W-1:0] wr_addr,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_bank,
  output logic [CNT_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_k,
  output logic             rd_last,
  output logic             blk_done,
  output logic             drop,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_state_t;
  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  localparam logic [CNT_W-1:0] K_SMALL_C = CNT_W'(K_SMALL);
  localparam logic [CNT_W-1:0] K_LARGE_C = CNT_W'(K_LARGE);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  bank_state_t      bank_state [2];
  logic [CNT_W-1:0] bank_len   [2];

  wr_state_t        wr_state_reg;
  rd_state_t        rd_state_reg;
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [CNT_W-1:0] wr_addr_reg;
  logic [CNT_W-1:0] rd_idx_reg;
  logic             blk_done_reg;
  logic             drop_reg;

  logic start_ok;
  logic wr_done;
  logic rd_start;
  logic rd_xfer;
  logic rd_finish;

  // A start is only taken when the writer is idle and the next bank in
  // rotation has been fully released by the reader at an earlier edge.
  assign start_ok  = blk_start && (wr_state_reg == W_IDLE) &&
                     (bank_state[wr_ptr_reg] == B_EMPTY);
  assign in_ready  = (wr_state_reg == W_FILL);
  assign wr_en     = in_valid && in_ready;
  assign wr_done   = wr_en && ((wr_addr_reg == bank_len[wr_ptr_reg] - CNT_ONE) || in_end);

  assign rd_start  = (rd_state_reg == R_IDLE) && (bank_state[rd_ptr_reg] == B_FULL);
  assign rd_valid  = (rd_state_reg == R_DRAIN);
  assign rd_last   = rd_valid && (rd_idx_reg == bank_len[rd_ptr_reg] - CNT_ONE);
  assign rd_xfer   = rd_valid && rd_ready;
  assign rd_finish = rd_xfer && rd_last;

  assign wr_bank   = wr_ptr_reg;
  assign wr_addr   = wr_addr_reg;
  assign rd_bank   = rd_ptr_reg;
  assign rd_idx    = rd_idx_reg;
  assign rd_k      = rd_valid ? bank_len[rd_ptr_reg] : '0;
  assign blk_done  = blk_done_reg;
  assign drop      = drop_reg;

  // Per-bank state. The four transitions require four different current
  // states, so writer and reader can never update the same bank together.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bank_state_t      state_reg;
    logic [CNT_W-1:0] len_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_reg <= B_EMPTY;
        len_reg   <= '0;
      end else if (start_ok && (wr_ptr_reg == 1'(gi))) begin
        state_reg <= B_FILL;
        len_reg   <= blk_size ? K_LARGE_C : K_SMALL_C;
      end else if (wr_done && (wr_ptr_reg == 1'(gi))) begin
        state_reg <= B_FULL;
        len_reg   <= wr_addr_reg + CNT_ONE;   // records early-end length
      end else if (rd_start && (rd_ptr_reg == 1'(gi))) begin
        state_reg <= B_DRAIN;
      end else if (rd_finish && (rd_ptr_reg == 1'(gi))) begin
        state_reg <= B_EMPTY;
      end
    end

    assign bank_state[gi] = state_reg;
    assign bank_len[gi]   = len_reg;
  end

  // Writer FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_reg <= W_IDLE;
      wr_ptr_reg   <= 1'b0;
      wr_addr_reg  <= '0;
      drop_reg     <= 1'b0;
    end else begin
      drop_reg <= blk_start && !start_ok;
      case (wr_state_reg)
        W_IDLE: begin
          if (start_ok) begin
            wr_state_reg <= W_FILL;
            wr_addr_reg  <= '0;
          end
        end
        W_FILL: begin
          if (wr_en) begin
            wr_addr_reg <= wr_addr_reg + CNT_ONE;
            if (wr_done) begin
              wr_state_reg <= W_IDLE;
              wr_ptr_reg   <= ~wr_ptr_reg;
            end
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  // Reader FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_reg <= R_IDLE;
      rd_ptr_reg   <= 1'b0;
      rd_idx_reg   <= '0;
      blk_done_reg <= 1'b0;
    end else begin
      blk_done_reg <= rd_finish;
      case (rd_state_reg)
        R_IDLE: begin
          if (rd_start) begin
            rd_state_reg <= R_DRAIN;
            rd_idx_reg   <= '0;
          end
        end
        R_DRAIN: begin
          if (rd_xfer) begin
            if (rd_last) begin
              rd_state_reg <= R_IDLE;
              rd_ptr_reg   <= ~rd_ptr_reg;
              rd_idx_reg   <= '0;
            end else begin
              rd_idx_reg <= rd_idx_reg + CNT_ONE;
            end
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

`ifdef INTLV_SCHED_ERRCNT_EN
  logic [7:0] drop_cnt_reg;

  // Counts in step with the drop pulse; sticks at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_reg <= 8'd0;
    end else if (blk_start && !start_ok && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
